// File: rtl/net_config_loader.sv
// net_config_loader: streams per-channel network config from memory at boot.
// Optional checksum validation is enabled by defining NET_CONFIG_CHECKSUM_EN.
module net_config_loader #(
  parameter int          NUM_CH       = 8,
  parameter int          ADDR_W       = 10,
  parameter int          BASE_ADDR    = 0,
  parameter int          RD_LATENCY   = 2,
  parameter logic [31:0] DEF_IP_BASE  = 32'h0a0300ff,
  parameter logic [31:0] DEF_MASK     = 32'hff000000,
  parameter logic [31:0] DEF_GW       = 32'h0a000001,
  parameter logic [31:0] DEF_TARGET   = 32'h0a000001,
  parameter logic [47:0] DEF_MAC_BASE = 48'h001b1affff00
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reload_i,
  output logic                  mem_en_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  output logic [32*NUM_CH-1:0]  cfg_ip_o,
  output logic [32*NUM_CH-1:0]  cfg_mask_o,
  output logic [32*NUM_CH-1:0]  cfg_gw_o,
  output logic [32*NUM_CH-1:0]  cfg_target_o,
  output logic [48*NUM_CH-1:0]  cfg_mac_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NUM_CH-1:0]     err_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = CH_W + 3;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(8 * NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             pending;
  logic             enter_issue;

  logic [RD_LATENCY-1:0] pv;
  logic [IDX_W-1:0]      pidx [RD_LATENCY];

  logic             cap_v;
  logic             cap_last;
  logic [IDX_W-1:0] cap_idx;
  logic [CH_W-1:0]  cap_ch;
  logic [7:0]       wsel;
  logic [31:0]      d;
  logic             cs_ok;

  logic [31:0] ip_q   [NUM_CH];
  logic [31:0] mask_q [NUM_CH];
  logic [31:0] gw_q   [NUM_CH];
  logic [31:0] tgt_q  [NUM_CH];
  logic [47:0] mac_q  [NUM_CH];

  logic [31:0] stg_ip;
  logic [31:0] stg_mask;
  logic [31:0] stg_gw;
  logic [31:0] stg_tgt;
  logic [47:0] stg_mac;
  logic        done_q;

  function automatic logic [31:0] def_ip(int c);
    return DEF_IP_BASE + (32'(c) << 16);
  endfunction

  function automatic logic [47:0] def_mac(int c);
    return DEF_MAC_BASE + 48'(c);
  endfunction

  assign cap_v    = pv[RD_LATENCY-1];
  assign cap_idx  = pidx[RD_LATENCY-1];
  assign cap_ch   = cap_idx[IDX_W-1:3];
  assign wsel     = 8'b1 << cap_idx[2:0];
  assign cap_last = cap_v && (cap_idx == LAST);
  assign d        = mem_rdata_i;

  assign enter_issue = (state == IDLE) && pending;
  assign mem_en_o    = (state == ISSUE);
  assign mem_addr_o  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
  assign busy_o      = (state != IDLE);
  assign done_o      = done_q;

  // FSM state, read index and the single-deep reload request flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b1;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (enter_issue)
        pending <= 1'b0;
      else if (reload_i)
        pending <= 1'b1;
    end
  end

  // Next state; the load ends on the edge its final word is captured.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (pending) begin
          state_nxt = ISSUE;
          idx_nxt   = '0;
        end
      end
      ISSUE: begin
        if (idx == LAST) begin
          state_nxt = cap_last ? IDLE : DRAIN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      DRAIN: begin
        if (cap_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tag pipeline: each issued read carries its index to the capture point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv <= '0;
      for (int i = 0; i < RD_LATENCY; i++)
        pidx[i] <= '0;
    end else begin
      pv[0]   <= (state_nxt == ISSUE);
      pidx[0] <= idx_nxt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
    end
  end

  // Staging of returned words and per-channel commit on the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ip_q[c]   <= def_ip(c);
        mask_q[c] <= DEF_MASK;
        gw_q[c]   <= DEF_GW;
        tgt_q[c]  <= DEF_TARGET;
        mac_q[c]  <= def_mac(c);
      end
      stg_ip   <= '0;
      stg_mask <= '0;
      stg_gw   <= '0;
      stg_tgt  <= '0;
      stg_mac  <= '0;
      done_q   <= 1'b0;
    end else if (cap_v) begin
      unique case (1'b1)
        wsel[0]: begin
          stg_ip   <= (|d) ? d : ip_q[cap_ch];
          stg_mask <= mask_q[cap_ch];
          stg_gw   <= gw_q[cap_ch];
          stg_tgt  <= tgt_q[cap_ch];
          stg_mac  <= mac_q[cap_ch];
        end
        wsel[1]: if (|d) stg_mask <= d;
        wsel[2]: if (|d) stg_gw <= d;
        wsel[3]: if (|d) stg_tgt <= d;
        wsel[4]: if (|d) stg_mac[47:16] <= d;
        wsel[5]: if (|d[31:16]) stg_mac[15:0] <= d[31:16];
        wsel[6]: ;
        wsel[7]: begin
          if (cs_ok) begin
            ip_q[cap_ch]   <= stg_ip;
            mask_q[cap_ch] <= stg_mask;
            gw_q[cap_ch]   <= stg_gw;
            tgt_q[cap_ch]  <= stg_tgt;
            mac_q[cap_ch]  <= stg_mac;
          end
        end
        default: ;
      endcase
      if (cap_last)
        done_q <= 1'b1;
    end
  end

`ifdef NET_CONFIG_CHECKSUM_EN
  logic [31:0]       xr;
  logic [31:0]       cs;
  logic [NUM_CH-1:0] err_q;

  // Running XOR of raw w0..w5 and the stored checksum word w6.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xr <= '0;
      cs <= '0;
    end else if (cap_v) begin
      if (wsel[0])
        xr <= d;
      else if (|wsel[5:1])
        xr <= xr ^ d;
      if (wsel[6])
        cs <= d;
    end
  end

  assign cs_ok = (xr == cs);

  // Error flags: cleared at each load start, set by a rejected commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= '0;
    else if (enter_issue)
      err_q <= '0;
    else if (cap_v && wsel[7] && !cs_ok)
      err_q[cap_ch] <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign cs_ok = 1'b1;
  assign err_o = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign cfg_ip_o[c*32 +: 32]     = ip_q[c];
    assign cfg_mask_o[c*32 +: 32]   = mask_q[c];
    assign cfg_gw_o[c*32 +: 32]     = gw_q[c];
    assign cfg_target_o[c*32 +: 32] = tgt_q[c];
    assign cfg_mac_o[c*48 +: 48]    = mac_q[c];
  end

endmodule

// File: tb/tb_net_config_loader.sv
// tb_net_config_loader: directed bench for net_config_loader.
// Checksum steps run only when NET_CONFIG_CHECKSUM_EN is defined.
module tb_net_config_loader;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         reload_i = 1'b0;
  logic         mem_en_o;
  logic [9:0]   mem_addr_o;
  logic [31:0]  mem_rdata_i = '0;
  logic [255:0] cfg_ip_o;
  logic [255:0] cfg_mask_o;
  logic [255:0] cfg_gw_o;
  logic [255:0] cfg_target_o;
  logic [383:0] cfg_mac_o;
  logic         busy_o;
  logic         done_o;
  logic [7:0]   err_o;

  logic [31:0] mem [1024];

  int n_chk = 0;
  int n_err = 0;

  net_config_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .reload_i     (reload_i),
    .mem_en_o     (mem_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .cfg_ip_o     (cfg_ip_o),
    .cfg_mask_o   (cfg_mask_o),
    .cfg_gw_o     (cfg_gw_o),
    .cfg_target_o (cfg_target_o),
    .cfg_mac_o    (cfg_mac_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Memory with one registered stage: data at edge k+2 for address after edge k.
  always @(posedge clk) mem_rdata_i <= mem[mem_addr_o];

  function automatic logic [31:0] ip_of(int c);
    return cfg_ip_o[c*32 +: 32];
  endfunction
  function automatic logic [31:0] mask_of(int c);
    return cfg_mask_o[c*32 +: 32];
  endfunction
  function automatic logic [31:0] gw_of(int c);
    return cfg_gw_o[c*32 +: 32];
  endfunction
  function automatic logic [31:0] tgt_of(int c);
    return cfg_target_o[c*32 +: 32];
  endfunction
  function automatic logic [47:0] mac_of(int c);
    return cfg_mac_o[c*48 +: 48];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rec(int c, logic [31:0] w0, logic [31:0] w1,
                         logic [31:0] w2, logic [31:0] w3,
                         logic [31:0] w4, logic [31:0] w5);
    mem[8*c+0] = w0;
    mem[8*c+1] = w1;
    mem[8*c+2] = w2;
    mem[8*c+3] = w3;
    mem[8*c+4] = w4;
    mem[8*c+5] = w5;
    mem[8*c+6] = w0 ^ w1 ^ w2 ^ w3 ^ w4 ^ w5;
    mem[8*c+7] = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // Reset state, defaults visible during reset.
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_en", mem_en_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ip1", ip_of(1), 32'h0a0400ff);
    chk("rst_mac7", mac_of(7), 48'h001b1affff07);
    reset_n = 1'b1;

    // Automatic load of all-zero memory.
    tick(1);
    chk("a_e1_en", mem_en_o, 1);
    chk("a_e1_addr", mem_addr_o, 0);
    chk("a_e1_busy", busy_o, 1);
    tick(64);
    chk("a_e65_done", done_o, 0);
    chk("a_e65_busy", busy_o, 1);
    tick(1);
    chk("a_e66_done", done_o, 1);
    chk("a_e66_busy", busy_o, 0);
    chk("a_ip1", ip_of(1), 32'h0a0400ff);
    chk("a_ip7", ip_of(7), 32'h0a0a00ff);
    chk("a_mac7", mac_of(7), 48'h001b1affff07);
    chk("a_mask0", mask_of(0), 32'hff000000);
    chk("a_gw5", gw_of(5), 32'h0a000001);
    chk("a_tgt3", tgt_of(3), 32'h0a000001);
    tick(3);
    chk("a_idle_busy", busy_o, 0);
    chk("a_idle_en", mem_en_o, 0);

    // Reload with channel 0 and channel 2 records.
    set_rec(0, 32'hc0a80a05, 32'hffffff00, 32'hc0a80a01,
            32'hc0a80a02, 32'h00112233, 32'h44550000);
    set_rec(2, 32'h0, 32'hffff0000, 32'h0, 32'h0, 32'h0, 32'h0);
    reload_i = 1'b1;
    tick(1);
    reload_i = 1'b0;
    chk("b_pend_busy", busy_o, 0);
    tick(1);
    chk("b_e1_busy", busy_o, 1);
    chk("b_e1_addr", mem_addr_o, 0);
    tick(8);
    chk("b_e9_ip0", ip_of(0), 32'h0a0300ff);
    tick(1);
    chk("b_e10_ip0", ip_of(0), 32'hc0a80a05);
    chk("b_e10_mask0", mask_of(0), 32'hffffff00);
    chk("b_e10_gw0", gw_of(0), 32'hc0a80a01);
    chk("b_e10_tgt0", tgt_of(0), 32'hc0a80a02);
    chk("b_e10_mac0", mac_of(0), 48'h001122334455);
    chk("b_e10_ip1", ip_of(1), 32'h0a0400ff);
    tick(16);
    chk("b_e26_mask2", mask_of(2), 32'hffff0000);
    chk("b_e26_ip2", ip_of(2), 32'h0a0500ff);
    chk("b_e26_mac2", mac_of(2), 48'h001b1affff02);
    tick(3);
    reload_i = 1'b1;
    tick(1);
    reload_i = 1'b0;
    chk("b_e30_addr", mem_addr_o, 29);
    chk("b_e30_en", mem_en_o, 1);
    reload_i = 1'b1;
    tick(1);
    reload_i = 1'b0;
    tick(34);
    chk("b_e65_busy", busy_o, 1);
    tick(1);
    chk("b_e66_busy", busy_o, 0);
    chk("b_e66_done", done_o, 1);

    // Queued reload picks up changed memory.
    set_rec(0, 32'h0a0b0c0d, 32'hffffff00, 32'hc0a80a01,
            32'hc0a80a02, 32'h00112233, 32'h44550000);
    tick(1);
    chk("q_e1_busy", busy_o, 1);
    chk("q_e1_addr", mem_addr_o, 0);
    tick(9);
    chk("q_e10_ip0", ip_of(0), 32'h0a0b0c0d);
    chk("q_e10_mask0", mask_of(0), 32'hffffff00);
    tick(56);
    chk("q_e66_busy", busy_o, 0);
    tick(5);
    chk("q_after_busy", busy_o, 0);
    chk("q_after_en", mem_en_o, 0);

    // Reset in the middle of a load.
    reload_i = 1'b1;
    tick(1);
    reload_i = 1'b0;
    tick(1);
    tick(29);
    chk("r_e30_ip0", ip_of(0), 32'h0a0b0c0d);
    chk("r_e30_addr", mem_addr_o, 29);
    reset_n = 1'b0;
    #1;
    chk("r_ip0", ip_of(0), 32'h0a0300ff);
    chk("r_mask2", mask_of(2), 32'hff000000);
    chk("r_mac0", mac_of(0), 48'h001b1affff00);
    chk("r_busy", busy_o, 0);
    chk("r_done", done_o, 0);
    chk("r_en", mem_en_o, 0);
    chk("r_addr", mem_addr_o, 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    chk("r_e1_en", mem_en_o, 1);
    chk("r_e1_addr", mem_addr_o, 0);
    tick(64);
    chk("r_e65_done", done_o, 0);
    tick(1);
    chk("r_e66_done", done_o, 1);
    chk("r_e66_busy", busy_o, 0);
    chk("r_e66_ip0", ip_of(0), 32'h0a0b0c0d);
    chk("r_e66_mask2", mask_of(2), 32'hffff0000);

`ifdef NET_CONFIG_CHECKSUM_EN
    // Corrupt checksum on channel 3.
    set_rec(3, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    mem[30] = mem[30] ^ 32'h1;
    reload_i = 1'b1;
    tick(1);
    reload_i = 1'b0;
    tick(1);
    tick(65);
    chk("c_busy", busy_o, 0);
    chk("c_err", err_o, 8'h08);
    chk("c_ip3", ip_of(3), 32'h0a0600ff);
    chk("c_ip0", ip_of(0), 32'h0a0b0c0d);
    set_rec(3, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    reload_i = 1'b1;
    tick(1);
    reload_i = 1'b0;
    tick(1);
    chk("c2_e1_err", err_o, 8'h00);
    tick(65);
    chk("c2_err", err_o, 8'h00);
    chk("c2_ip3", ip_of(3), 32'h12345678);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
